ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 101 ++++++++++
 tb/tb_ex_mem_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register as a 2-entry skid FIFO, with a registered
// branch-taken pulse and a saturating back-pressure counter.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              zero_flag,
  input  logic [DATA_W-1:0] add_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  rd_addr,
  input  logic [4:0]        ctrl,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic [3:0]        mem_ctrl,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic [15:0]       stall_cycles
);

  logic [1:0]        cnt_q, cnt_d;
  logic              wptr_q, rptr_q;
  logic [DATA_W-1:0] alu_q [2];
  logic [DATA_W-1:0] sd_q  [2];
  logic [REG_W-1:0]  rd_q  [2];
  logic [3:0]        ctl_q [2];
  logic              bt_q;
  logic [DATA_W-1:0] tgt_q;
  logic [15:0]       stall_q;
  logic              push, pop, take;

  assign ex_ready  = ~cnt_q[1];
  assign mem_valid = (cnt_q != 2'd0);
  assign push      = ex_valid & ex_ready & ~flush;
  assign pop       = mem_valid & mem_ready & ~flush;
  assign take      = push & ctrl[4] & zero_flag;

  assign mem_alu_out    = alu_q[rptr_q];
  assign mem_store_data = sd_q[rptr_q];
  assign mem_rd         = rd_q[rptr_q];
  assign mem_ctrl       = mem_valid ? ctl_q[rptr_q] : 4'd0;

  assign branch_taken  = bt_q;
  assign branch_target = tgt_q;
  assign stall_cycles  = stall_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      flush:         cnt_d = 2'd0;
      push && !pop:  cnt_d = cnt_q + 2'd1;
      pop && !push:  cnt_d = cnt_q - 2'd1;
      default:       cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      bt_q    <= 1'b0;
      tgt_q   <= '0;
      stall_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
      // Flush realigns both pointers so the buffer restarts from slot 0
      if (flush) begin
        wptr_q <= 1'b0;
        rptr_q <= 1'b0;
      end else begin
        wptr_q <= wptr_q ^ push;
        rptr_q <= rptr_q ^ pop;
      end
      bt_q <= take;
      if (take)
        tgt_q <= add_result;
      if (ex_valid && !ex_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  // Payload needs no reset: it is only observed while mem_valid is high
  always_ff @(posedge clk) begin
    if (push) begin
      alu_q[wptr_q] <= alu_out;
      sd_q[wptr_q]  <= store_data;
      rd_q[wptr_q]  <= rd_addr;
      ctl_q[wptr_q] <= ctrl[3:0];
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with a queue scoreboard and a small
// reference model of count, branch pulse and stall counter.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] s;
    logic [4:0]  r;
    logic [3:0]  c;
  } ent_t;

  logic        clk, rst;
  logic        ex_valid, ex_ready, zero_flag, flush;
  logic [31:0] alu_out, add_result, store_data;
  logic [4:0]  rd_addr, ctrl;
  logic        mem_valid, mem_ready, branch_taken;
  logic [31:0] mem_alu_out, mem_store_data, branch_target;
  logic [4:0]  mem_rd;
  logic [3:0]  mem_ctrl;
  logic [15:0] stall_cycles;

  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_out(alu_out), .zero_flag(zero_flag),
    .add_result(add_result), .store_data(store_data),
    .rd_addr(rd_addr), .ctrl(ctrl), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_ctrl(mem_ctrl),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nchk = 0;
  int          npass = 0;
  int          nfail = 0;
  ent_t        sb[$];
  int          mcnt = 0;
  logic        mbt = 1'b0;
  logic [31:0] mtgt = '0;
  logic [15:0] mstall = '0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] a,
                     input logic [31:0] s, input logic [4:0] r,
                     input logic [4:0] c, input logic z,
                     input logic [31:0] t);
    ex_valid   = v;
    alu_out    = a;
    store_data = s;
    rd_addr    = r;
    ctrl       = c;
    zero_flag  = z;
    add_result = t;
  endtask

  task automatic model_reset();
    sb.delete();
    mcnt   = 0;
    mbt    = 1'b0;
    mtgt   = '0;
    mstall = '0;
  endtask

  // Check at negedge, advance model, then step to just past posedge
  task automatic cyc();
    ent_t e;
    bit   psh, pp;
    @(negedge clk);
    chk("ex_ready", ex_ready, mcnt < 2);
    chk("mem_valid", mem_valid, mcnt != 0);
    if (mcnt == 0) chk("ctrl_idle", mem_ctrl, 4'd0);
    else chk("head", {mem_alu_out, mem_store_data, mem_rd, mem_ctrl}, sb[0]);
    chk("br_taken", branch_taken, mbt);
    chk("br_target", branch_target, mtgt);
    chk("stall", stall_cycles, mstall);
    if (ex_valid && mcnt >= 2 && mstall != 16'hFFFF) mstall++;
    mbt = 1'b0;
    if (flush) begin
      sb.delete();
      mcnt = 0;
    end else begin
      psh = ex_valid && mcnt < 2;
      pp  = mcnt != 0 && mem_ready;
      if (pp) e = sb.pop_front();
      if (psh) begin
        sb.push_back('{alu_out, store_data, rd_addr, ctrl[3:0]});
        if (ctrl[4] && zero_flag) begin
          mbt  = 1'b1;
          mtgt = add_result;
        end
      end
      mcnt = mcnt + int'(psh) - int'(pp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    mem_ready = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_ready", ex_ready, 1'b1);
    chk("rst_valid", mem_valid, 1'b0);
    chk("rst_ctrl", mem_ctrl, 4'd0);
    chk("rst_bt", branch_taken, 1'b0);
    chk("rst_tgt", branch_target, 32'd0);
    chk("rst_stall", stall_cycles, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();

    // Single pass through an empty buffer
    mem_ready = 1'b1;
    drv(1, 32'h10, 32'hAAAA_0001, 5'd5, 5'b00001, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("pass_valid", mem_valid, 1'b1);
    chk("pass_alu", mem_alu_out, 32'h10);
    chk("pass_rd", mem_rd, 5'd5);
    chk("pass_ctrl", mem_ctrl, 4'b0001);
    cyc();
    chk("pass_drain", mem_valid, 1'b0);
    cyc();

    // Back-pressure: A, B fill, C held upstream
    mem_ready = 1'b0;
    drv(1, 32'd1, 32'h11, 5'd1, 5'b00011, 0, 0);
    cyc();
    drv(1, 32'd2, 32'h22, 5'd2, 5'b01010, 0, 0);
    cyc();
    chk("bp_ready", ex_ready, 1'b0);
    drv(1, 32'd3, 32'h33, 5'd3, 5'b00101, 0, 0);
    cyc();
    chk("bp_stall", stall_cycles, 16'd1);
    chk("bp_hold", mem_alu_out, 32'd1);
    mem_ready = 1'b1;
    cyc();
    chk("bp_ready_rise", ex_ready, 1'b1);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();

    // Branch taken and not taken
    drv(1, 32'h5, 32'h0, 5'd0, 5'b10000, 1, 32'h40);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("br_pulse", branch_taken, 1'b1);
    chk("br_tgt40", branch_target, 32'h40);
    cyc();
    chk("br_once", branch_taken, 1'b0);
    drv(1, 32'h6, 32'h0, 5'd0, 5'b10000, 0, 32'h80);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("br_nt", branch_taken, 1'b0);
    chk("br_keep", branch_target, 32'h40);
    cyc();

    // Flush with two buffered and a concurrent branch push
    mem_ready = 1'b0;
    drv(1, 32'h100, 32'h1, 5'd7, 5'b00001, 0, 0);
    cyc();
    drv(1, 32'h200, 32'h2, 5'd8, 5'b00001, 0, 0);
    cyc();
    flush = 1'b1;
    mem_ready = 1'b1;
    drv(1, 32'h300, 32'h3, 5'd9, 5'b10001, 1, 32'hC0);
    cyc();
    flush = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("fl_valid", mem_valid, 1'b0);
    chk("fl_bt", branch_taken, 1'b0);
    cyc();
    cyc();

    // Asynchronous reset mid-cycle with two entries and stall=7
    mem_ready = 1'b0;
    drv(1, 32'h400, 32'h4, 5'd10, 5'b00001, 0, 0);
    cyc();
    drv(1, 32'h500, 32'h5, 5'd11, 5'b00001, 0, 0);
    cyc();
    for (int i = 0; i < 20 && mstall < 16'd7; i++) cyc();
    chk("ar_pre", stall_cycles, 16'd7);
    #1 rst = 1'b1;
    #1;
    chk("ar_valid", mem_valid, 1'b0);
    chk("ar_ready", ex_ready, 1'b1);
    chk("ar_stall", stall_cycles, 16'd0);
    chk("ar_ctrl", mem_ctrl, 4'd0);
    chk("ar_tgt", branch_target, 32'd0);
    #1 rst = 1'b0;
    model_reset();
    mem_ready = 1'b1;
    drv(1, 32'h600, 32'h6, 5'd12, 5'b00110, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("ar_first", mem_alu_out, 32'h600);
    cyc();
    cyc();

    // Saturating stall counter
    mem_ready = 1'b0;
    drv(1, 32'h700, 32'h7, 5'd13, 5'b00001, 0, 0);
    for (int i = 0; i < 70000; i++) cyc();
    chk("sat", stall_cycles, 16'hFFFF);
    cyc();
    chk("sat_nowrap", stall_cycles, 16'hFFFF);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
